// File: rtl/xor_cipher_pkg.sv
// Shared opcode constants and controller state encoding for the XOR cipher front end.
package xor_cipher_pkg;

    localparam logic [7:0] OP_LOAD_KEY = 8'hA5;
    localparam logic [7:0] OP_LOAD_MSG = 8'h5A;
    localparam logic [7:0] OP_START    = 8'hC3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_KEY,
        ST_MSG,
        ST_WAIT_ENC,
        ST_ERR
    } ctrl_state_t;

endpackage

// File: rtl/frame_bit_counter.sv
// Up-counter with synchronous clear and a compare-against-limit terminal flag.
module frame_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic             at_limit_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_limit_c = (count == limit);

endmodule

// File: rtl/xor_session_ctrl.sv
// Framed serial command sequencer: parses host opcodes, forwards key/message payloads
// to the cipher datapath and supervises the encryption run with a watchdog.
module xor_session_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int unsigned KEY_SIZE = 32,
    parameter int unsigned MSG_SIZE = 512,
    parameter int unsigned TIMEOUT  = 2048
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iFrame,
    input  logic iSerial_in,
    input  logic iSerial_end,
    output logic oSerial_data,
    output logic oLoad_key,
    output logic oLoad_msg,
    output logic oEn,
    output logic oBusy,
    output logic oDone,
    output logic oErr
);

    localparam int unsigned PAY_MAX = (KEY_SIZE > MSG_SIZE) ? KEY_SIZE : MSG_SIZE;
    localparam int unsigned PAY_W   = $clog2(PAY_MAX) + 1;
    localparam int unsigned WD_W    = $clog2(TIMEOUT) + 1;

    ctrl_state_t state;
    logic [6:0]  op_bits;
    logic [2:0]  op_cnt;
    logic        start_pend;
    logic        key_ok;
    logic        msg_ok;
    logic [7:0]  op_word;
    logic        load_state;
    logic        pay_full;
    logic        wd_full;
    logic [PAY_W-1:0] pay_limit;

    assign op_word    = {op_bits, iSerial_in};
    assign load_state = (state == ST_KEY) || (state == ST_MSG);
    assign pay_limit  = (state == ST_KEY) ? PAY_W'(KEY_SIZE) : PAY_W'(MSG_SIZE);

    frame_bit_counter #(.WIDTH(PAY_W)) u_pay_cnt (
        .clk        (iClk),
        .rst_n      (iRst),
        .clr        (!load_state),
        .inc        (load_state && iFrame && !pay_full),
        .limit      (pay_limit),
        .at_limit_c (pay_full)
    );

    frame_bit_counter #(.WIDTH(WD_W)) u_wd_cnt (
        .clk        (iClk),
        .rst_n      (iRst),
        .clr        (state != ST_WAIT_ENC),
        .inc        ((state == ST_WAIT_ENC) && !wd_full),
        .limit      (WD_W'(TIMEOUT)),
        .at_limit_c (wd_full)
    );

    // State change with the state-decoded status flags registered alongside it.
    task automatic go(input ctrl_state_t nxt);
        state <= nxt;
        oBusy <= (nxt != ST_IDLE);
        oEn   <= (nxt == ST_KEY) || (nxt == ST_MSG) || (nxt == ST_WAIT_ENC);
        oErr  <= (nxt == ST_ERR);
    endtask

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state        <= ST_IDLE;
            op_bits      <= '0;
            op_cnt       <= '0;
            start_pend   <= 1'b0;
            key_ok       <= 1'b0;
            msg_ok       <= 1'b0;
            oSerial_data <= 1'b0;
            oLoad_key    <= 1'b0;
            oLoad_msg    <= 1'b0;
            oEn          <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oErr         <= 1'b0;
        end else begin
            oSerial_data <= 1'b0;
            oLoad_key    <= 1'b0;
            oLoad_msg    <= 1'b0;
            oDone        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iFrame) begin
                        go(ST_OPCODE);
                        op_bits    <= {6'b0, iSerial_in};
                        op_cnt     <= 3'd1;
                        start_pend <= 1'b0;
                    end
                end
                ST_OPCODE: begin
                    if (start_pend) begin
                        // Start accepted only if the frame closes right after the opcode.
                        if (iFrame) begin
                            go(ST_ERR);
                        end else begin
                            go(ST_WAIT_ENC);
                            key_ok <= 1'b0;
                            msg_ok <= 1'b0;
                        end
                    end else if (!iFrame) begin
                        go(ST_ERR);
                    end else begin
                        op_bits <= op_word[6:0];
                        op_cnt  <= op_cnt + 3'd1;
                        if (op_cnt == 3'd7) begin
                            case (op_word)
                                OP_LOAD_KEY: go(ST_KEY);
                                OP_LOAD_MSG: go(ST_MSG);
                                OP_START: begin
                                    if (key_ok && msg_ok) start_pend <= 1'b1;
                                    else                  go(ST_ERR);
                                end
                                default:     go(ST_ERR);
                            endcase
                        end
                    end
                end
                ST_KEY, ST_MSG: begin
                    if (iFrame) begin
                        if (pay_full) begin
                            go(ST_ERR);
                        end else begin
                            oSerial_data <= iSerial_in;
                            oLoad_key    <= (state == ST_KEY);
                            oLoad_msg    <= (state == ST_MSG);
                        end
                    end else if (pay_full) begin
                        if (state == ST_KEY) key_ok <= 1'b1;
                        else                 msg_ok <= 1'b1;
                        go(ST_IDLE);
                    end else begin
                        go(ST_ERR);
                    end
                end
                ST_WAIT_ENC: begin
                    if (iSerial_end) begin
                        oDone <= 1'b1;
                        go(ST_IDLE);
                    end else if (wd_full) begin
                        go(ST_ERR);
                    end
                end
                ST_ERR: begin
                    key_ok <= 1'b0;
                    msg_ok <= 1'b0;
                    if (!iFrame) go(ST_IDLE);
                end
                default: go(ST_IDLE);
            endcase
        end
    end

endmodule
